// File: rtl/spi_reg_if.sv
// spi_reg_if: SPI mode-0 slave that turns 16-bit frames into register write/read strobes.
// Revision 1.0
`default_nettype none

module spi_reg_if #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_d;

   state_t                 r_state;
   logic [4:0]             r_cnt;
   logic [7:0]             r_rx;
   logic [7:0]             r_tx;
   logic                   r_rw;
   logic                   r_load;
   logic                   r_miso_oe;
   logic [ADDR_W-1:0]      r_addr;
   logic [7:0]             r_wdata;
   logic                   r_we;
   logic                   r_re;

   logic                   w_sclk_s;
   logic                   w_cs_s;
   logic                   w_mosi_s;
   logic                   w_rise;
   logic                   w_fall;
   logic [7:0]             w_rx_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_sclk_d    <= w_sclk_s;
      end
   end

   assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
   assign w_rise    = w_sclk_s & ~r_sclk_d;
   assign w_fall    = ~w_sclk_s & r_sclk_d;
   assign w_rx_next = {r_rx[6:0], w_mosi_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 5'd0;
         r_rx      <= 8'd0;
         r_tx      <= 8'd0;
         r_rw      <= 1'b0;
         r_load    <= 1'b0;
         r_miso_oe <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= 8'd0;
         r_we      <= 1'b0;
         r_re      <= 1'b0;
      end else begin
         r_we      <= 1'b0;
         r_re      <= 1'b0;
         r_load    <= r_re;
         r_miso_oe <= ~w_cs_s;
         // Deasserted chip select overrides any edge seen in the same cycle.
         if (w_cs_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_tx    <= 8'd0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_ADDR;
                  r_cnt   <= 5'd0;
                  r_rx    <= 8'd0;
                  r_tx    <= 8'd0;
                  r_rw    <= 1'b0;
               end
               ST_ADDR: begin
                  if (w_rise) begin
                     r_rx  <= w_rx_next;
                     r_cnt <= r_cnt + 5'd1;
                     if (r_cnt == 5'd7) begin
                        r_rw    <= w_rx_next[7];
                        r_addr  <= w_rx_next[ADDR_W-1:0];
                        r_re    <= ~w_rx_next[7];
                        r_state <= ST_DATA;
                     end
                  end
               end
               ST_DATA: begin
                  if (w_rise) begin
                     r_rx  <= w_rx_next;
                     r_cnt <= r_cnt + 5'd1;
                     if (r_cnt == 5'd15) begin
                        r_state <= ST_DONE;
                        if (r_rw) begin
                           r_we    <= 1'b1;
                           r_wdata <= w_rx_next;
                        end
                     end
                  end
                  // The 8th fall keeps bit 7 on the pin; shifting starts at the 9th fall.
                  if (r_load) begin
                     r_tx <= reg_rdata;
                  end else if (w_fall && (r_cnt > 5'd8)) begin
                     r_tx <= {r_tx[6:0], 1'b0};
                  end
               end
               ST_DONE: begin
                  r_state <= ST_DONE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign miso      = r_tx[7];
   assign miso_oe   = r_miso_oe;
   assign reg_addr  = r_addr;
   assign reg_wdata = r_wdata;
   assign reg_we    = r_we;
   assign reg_re    = r_re;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_if.sv
// tb_spi_reg_if: directed SPI master with a strobe scoreboard and a small register-file model.
// Revision 1.0
`default_nettype none

module tb_spi_reg_if;

   logic       clk;
   logic       rst_n;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;

   int errors = 0;
   int checks = 0;
   int we_seen = 0;
   int re_seen = 0;
   int we_pushed = 0;
   int re_pushed = 0;
   logic prev_we = 1'b0;
   logic prev_re = 1'b0;

   logic [14:0] we_q[$];
   logic [6:0]  re_q[$];
   logic [7:0]  rd_q[$];
   logic [7:0]  mem [128];
   logic [23:0] cap;

   spi_reg_if #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso),
      .miso_oe   (miso_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: read data appears the cycle after reg_re.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
         mem[7'h13] <= 8'hA7;
         reg_rdata  <= 8'h00;
      end else begin
         if (reg_we) mem[reg_addr] <= reg_wdata;
         if (reg_re) reg_rdata <= mem[reg_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [14:0] e;
      if (reg_we || reg_re) check("we_re_excl", {31'd0, reg_we & reg_re}, 32'd0);
      if (reg_we) begin
         we_seen++;
         check("we_width", {31'd0, prev_we}, 32'd0);
         check("we_expected", {31'd0, we_q.size() > 0}, 32'd1);
         if (we_q.size() > 0) begin
            e = we_q.pop_front();
            check("we_addr", {25'd0, reg_addr}, {25'd0, e[14:8]});
            check("we_data", {24'd0, reg_wdata}, {24'd0, e[7:0]});
         end
      end
      if (reg_re) begin
         re_seen++;
         check("re_width", {31'd0, prev_re}, 32'd0);
         check("re_expected", {31'd0, re_q.size() > 0}, 32'd1);
         if (re_q.size() > 0) check("re_addr", {25'd0, reg_addr}, {25'd0, re_q.pop_front()});
      end
      prev_we = reg_we;
      prev_re = reg_re;
   end

   task automatic push_write(input logic [6:0] a, input logic [7:0] d);
      we_q.push_back({a, d});
      we_pushed++;
   endtask

   task automatic push_read(input logic [6:0] a, input logic [7:0] d);
      re_q.push_back(a);
      rd_q.push_back(d);
      re_pushed++;
   endtask

   // Mode-0 master, sclk = clk/8; bits are left-aligned in a 24-bit word.
   task automatic run_frame(input logic [23:0] bits, input int n, input bit end_cs,
                            input int gap, output logic [23:0] c);
      c    = '0;
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         mosi = bits[23-i];
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         c    = {c[22:0], miso};
         check("oe_in_frame", {31'd0, miso_oe}, 32'd1);
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
      if (end_cs) begin
         repeat (4) @(negedge clk);
         cs_n = 1'b1;
         mosi = 1'b0;
         repeat (gap) @(negedge clk);
         if (gap >= 8) begin
            check("oe_idle", {31'd0, miso_oe}, 32'd0);
            check("miso_idle", {31'd0, miso}, 32'd0);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      sclk  = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_miso", {31'd0, miso}, 32'd0);
      check("rst_oe", {31'd0, miso_oe}, 32'd0);
      check("rst_addr", {25'd0, reg_addr}, 32'd0);
      check("rst_wdata", {24'd0, reg_wdata}, 32'd0);
      check("rst_we", {31'd0, reg_we}, 32'd0);
      check("rst_re", {31'd0, reg_re}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      push_write(7'h0A, 8'h5C);
      run_frame({16'h8A5C, 8'h00}, 16, 1'b1, 8, cap);
      check("wr_miso_addr", {24'd0, cap[15:8]}, 32'd0);
      check("wr_miso_data", {24'd0, cap[7:0]}, 32'd0);

      push_read(7'h13, 8'hA7);
      run_frame({16'h1300, 8'h00}, 16, 1'b1, 8, cap);
      check("rd_miso_addr", {24'd0, cap[15:8]}, 32'd0);
      check("rd_data_13", {24'd0, cap[7:0]}, {24'd0, rd_q.pop_front()});

      run_frame({16'h84C0, 8'h00}, 12, 1'b1, 8, cap);
      push_write(7'h01, 8'h01);
      run_frame({16'h8101, 8'h00}, 16, 1'b1, 8, cap);

      push_write(7'h0F, 8'h33);
      run_frame({16'h8F33, 8'hFF}, 24, 1'b1, 8, cap);

      push_write(7'h02, 8'h55);
      run_frame({16'h8255, 8'h00}, 16, 1'b1, 4, cap);
      push_read(7'h02, 8'h55);
      run_frame({16'h0200, 8'h00}, 16, 1'b1, 8, cap);
      check("rd_data_b2b", {24'd0, cap[7:0]}, {24'd0, rd_q.pop_front()});

      run_frame({16'h85AA, 8'h00}, 12, 1'b0, 0, cap);
      check("pre_rst_addr", {25'd0, reg_addr}, 32'h05);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_miso", {31'd0, miso}, 32'd0);
      check("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
      check("mid_rst_addr", {25'd0, reg_addr}, 32'd0);
      check("mid_rst_wdata", {24'd0, reg_wdata}, 32'd0);
      check("mid_rst_we", {31'd0, reg_we}, 32'd0);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      push_write(7'h11, 8'h77);
      run_frame({16'h9177, 8'h00}, 16, 1'b1, 8, cap);
      push_read(7'h11, 8'h77);
      run_frame({16'h1100, 8'h00}, 16, 1'b1, 8, cap);
      check("rd_data_post_rst", {24'd0, cap[7:0]}, {24'd0, rd_q.pop_front()});

      repeat (20) @(negedge clk);
      check("we_count", we_seen, we_pushed);
      check("re_count", re_seen, re_pushed);
      check("we_q_empty", we_q.size(), 32'd0);
      check("re_q_empty", re_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
